// File: rtl/rv32v_fu_result_writer_if.sv
// Bundle between one vector FU (start/beat side) and the ROB result port.
// The writer sits on the slave modport; the FU/decode/ROB environment sits on master.
interface rv32v_fu_result_writer_if #(
  parameter int NUM   = 32,
  parameter int LANES = 2,
  parameter int OFF_W = 5,
  parameter int VL_W  = 8
);
  localparam int IDX_W = $clog2(NUM);

  logic                   start;
  logic [IDX_W-1:0]       start_index;
  logic [4:0]             start_vd;
  logic [VL_W-1:0]        start_vl;
  logic [1:0]             start_sew;
  logic                   busy;
  logic                   beat_valid;
  logic [32*LANES-1:0]    beat_data;
  logic [LANES-1:0]       beat_exc;
  logic                   beat_ready;
  logic                   flush;
  logic [IDX_W-1:0]       index_o;
  logic [OFF_W-1:0]       woffset_o;
  logic [32*LANES-1:0]    wdata_o;
  logic [4:0]             vd_o;
  logic [LANES-1:0]       wen_o;
  logic [1:0]             sew_o;
  logic [VL_W-1:0]        vl_o;
  logic                   exception_o;
  logic [OFF_W-1:0]       exception_index_o;
  logic                   ready_o;

  modport master (
    output start, start_index, start_vd, start_vl, start_sew,
    output beat_valid, beat_data, beat_exc, flush,
    input  busy, beat_ready,
    input  index_o, woffset_o, wdata_o, vd_o, wen_o, sew_o, vl_o,
    input  exception_o, exception_index_o, ready_o
  );

  modport slave (
    input  start, start_index, start_vd, start_vl, start_sew,
    input  beat_valid, beat_data, beat_exc, flush,
    output busy, beat_ready,
    output index_o, woffset_o, wdata_o, vd_o, wen_o, sew_o, vl_o,
    output exception_o, exception_index_o, ready_o
  );
endinterface

// File: rtl/rv32v_fu_result_writer.sv
// Packs FU lane results into ROB write beats, tracking element offset, vl
// truncation, first-fault reporting and flush squash.
module rv32v_fu_lane #(
  parameter int LANE  = 0,
  parameter int OFF_W = 5,
  parameter int VL_W  = 8,
  parameter int CW    = 10
) (
  input  logic [OFF_W:0]    elem_cnt,
  input  logic [VL_W-1:0]   vl,
  input  logic              exc,
  output logic              in_range,
  output logic              exc_hit
);
  logic [CW-1:0] pos;
  assign pos      = CW'(elem_cnt) + CW'(LANE);
  assign in_range = pos < CW'(vl);
  assign exc_hit  = exc & in_range;
endmodule

module rv32v_fu_result_writer #(
  parameter int NUM   = 32,
  parameter int LANES = 2,
  parameter int OFF_W = 5,
  parameter int VL_W  = 8
) (
  input logic CLK,
  input logic nRST,
  rv32v_fu_result_writer_if.slave wb
);
  localparam int IDX_W = $clog2(NUM);
  // One extra bit over the wider operand so elem_cnt+LANES never wraps in compares.
  localparam int CW = ((OFF_W + 1 > VL_W) ? OFF_W + 1 : VL_W) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

  state_t              state;
  logic [OFF_W:0]      elem_cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [4:0]          vd_q;
  logic [VL_W-1:0]     vl_q;
  logic [1:0]          sew_q;

  logic [LANES-1:0]    in_range, exc_hit, wen_beat;
  logic                fault, last;
  logic [OFF_W-1:0]    k_off, exc_index;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rv32v_fu_lane #(.LANE(i), .OFF_W(OFF_W), .VL_W(VL_W), .CW(CW)) u_lane (
      .elem_cnt (elem_cnt),
      .vl       (vl_q),
      .exc      (wb.beat_exc[i]),
      .in_range (in_range[i]),
      .exc_hit  (exc_hit[i])
    );
  end

  // Lanes at or above the first fault are not written; lanes below it are.
  always_comb begin
    logic seen;
    seen     = 1'b0;
    wen_beat = '0;
    k_off    = '0;
    for (int i = 0; i < LANES; i++) begin
      seen        = seen | exc_hit[i];
      wen_beat[i] = in_range[i] & ~seen;
    end
    for (int i = LANES - 1; i >= 0; i--)
      if (exc_hit[i]) k_off = OFF_W'(i);
    fault     = |exc_hit;
    exc_index = elem_cnt[OFF_W-1:0] + k_off;
    last      = (CW'(elem_cnt) + CW'(LANES)) >= CW'(vl_q);
  end

  assign wb.busy       = (state != IDLE);
  assign wb.beat_ready = (state == ACTIVE) || (state == SKIP);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state                <= IDLE;
      elem_cnt             <= '0;
      idx_q                <= '0;
      vd_q                 <= '0;
      vl_q                 <= '0;
      sew_q                <= '0;
      wb.ready_o           <= 1'b0;
      wb.index_o           <= '0;
      wb.woffset_o         <= '0;
      wb.wdata_o           <= '0;
      wb.vd_o              <= '0;
      wb.wen_o             <= '0;
      wb.sew_o             <= '0;
      wb.vl_o              <= '0;
      wb.exception_o       <= 1'b0;
      wb.exception_index_o <= '0;
    end else begin
      wb.ready_o <= 1'b0;
      if (wb.flush) begin
        state    <= IDLE;
        elem_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (wb.start) begin
            if (wb.start_vl != '0) begin
              idx_q    <= wb.start_index;
              vd_q     <= wb.start_vd;
              vl_q     <= wb.start_vl;
              sew_q    <= wb.start_sew;
              elem_cnt <= '0;
              state    <= ACTIVE;
            end else begin
              // Empty instruction: one write-less strobe so the ROB entry retires.
              wb.ready_o           <= 1'b1;
              wb.index_o           <= wb.start_index;
              wb.vd_o              <= wb.start_vd;
              wb.vl_o              <= wb.start_vl;
              wb.sew_o             <= wb.start_sew;
              wb.woffset_o         <= '0;
              wb.wen_o             <= '0;
              wb.exception_o       <= 1'b0;
              wb.exception_index_o <= '0;
            end
          end
          ACTIVE: if (wb.beat_valid) begin
            wb.ready_o           <= 1'b1;
            wb.index_o           <= idx_q;
            wb.vd_o              <= vd_q;
            wb.vl_o              <= vl_q;
            wb.sew_o             <= sew_q;
            wb.woffset_o         <= elem_cnt[OFF_W-1:0];
            wb.wdata_o           <= wb.beat_data;
            wb.wen_o             <= wen_beat;
            wb.exception_o       <= fault;
            wb.exception_index_o <= fault ? exc_index : '0;
            elem_cnt             <= elem_cnt + (OFF_W+1)'(LANES);
            state                <= last ? IDLE : (fault ? SKIP : ACTIVE);
          end
          SKIP: if (wb.beat_valid) begin
            elem_cnt <= elem_cnt + (OFF_W+1)'(LANES);
            if (last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  start_only_in_idle: assert property (@(posedge CLK) disable iff (!nRST)
    !(wb.start && state != IDLE));
endmodule
